// File: rtl/div_iter_if.sv
// ============================================================================
// Module      : div_iter_if
// Description : Issue/completion bundle between the integer issue queue and
//               the iterative divider.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface div_iter_if #(
    parameter int W                   = 32,
    parameter int LG_ROB_ENTRIES      = 6,
    parameter int LG_HILO_PRF_ENTRIES = 6,
    parameter int OPCODE_W            = 6
);
    logic [OPCODE_W-1:0]            opcode;
    logic                           go;
    logic [W-1:0]                   src_A;
    logic [W-1:0]                   src_B;
    logic [LG_ROB_ENTRIES-1:0]      rob_ptr_in;
    logic [LG_HILO_PRF_ENTRIES-1:0] hilo_prf_ptr_in;

    logic                           ready;
    logic [2*W-1:0]                 y;
    logic                           complete;
    logic [LG_ROB_ENTRIES-1:0]      rob_ptr_out;
    logic                           hilo_prf_ptr_val_out;
    logic [LG_HILO_PRF_ENTRIES-1:0] hilo_prf_ptr_out;

    modport master (
        output opcode, go, src_A, src_B, rob_ptr_in, hilo_prf_ptr_in,
        input  ready, y, complete, rob_ptr_out, hilo_prf_ptr_val_out, hilo_prf_ptr_out
    );

    modport slave (
        input  opcode, go, src_A, src_B, rob_ptr_in, hilo_prf_ptr_in,
        output ready, y, complete, rob_ptr_out, hilo_prf_ptr_val_out, hilo_prf_ptr_out
    );
endinterface

`default_nettype wire

// File: rtl/div_iter.sv
// ============================================================================
// Module      : div_iter
// Description : Unpipelined radix-2 restoring divider for DIV/DIVU, result
//               packed as {remainder, quotient} for the hilo register file.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module div_iter #(
    parameter int                W                   = 32,
    parameter int                LG_ROB_ENTRIES      = 6,
    parameter int                LG_HILO_PRF_ENTRIES = 6,
    parameter int                OPCODE_W            = 6,
    parameter logic [OPCODE_W-1:0] OP_DIVU           = 6'h1B
) (
    input  logic      clk,
    input  logic      reset,
    div_iter_if.slave bus
);
    localparam int                CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(W - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_FIXUP  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                         state_q;
    logic [W-1:0]                   rem_q;
    logic [W-1:0]                   quo_q;
    logic [W-1:0]                   divisor_q;
    logic [W-1:0]                   a_raw_q;
    logic                           signed_q;
    logic                           a_neg_q;
    logic                           b_neg_q;
    logic                           b_zero_q;
    logic [CNT_W-1:0]               cnt_q;
    logic                           ready_q;
    logic                           complete_q;
    logic [2*W-1:0]                 y_q;
    logic [LG_ROB_ENTRIES-1:0]      rob_q;
    logic [LG_HILO_PRF_ENTRIES-1:0] hilo_q;

    logic                           is_signed_d;
    logic [W-1:0]                   a_mag_d;
    logic [W-1:0]                   b_mag_d;
    logic [W:0]                     shift_d;
    logic [W:0]                     trial_d;
    logic [W-1:0]                   quo_fix_d;
    logic [W-1:0]                   rem_fix_d;
    logic [2*W-1:0]                 result_d;

    always_comb begin
        is_signed_d = (bus.opcode != OP_DIVU);
        a_mag_d     = (is_signed_d && bus.src_A[W-1]) ? -bus.src_A : bus.src_A;
        b_mag_d     = (is_signed_d && bus.src_B[W-1]) ? -bus.src_B : bus.src_B;

        // Partial remainder stays below the divisor, so bit W of the shifted
        // value is always zero when the trial subtraction is rejected.
        shift_d     = {rem_q, quo_q[W-1]};
        trial_d     = shift_d - {1'b0, divisor_q};

        quo_fix_d   = (signed_q && (a_neg_q ^ b_neg_q)) ? -quo_q : quo_q;
        rem_fix_d   = (signed_q && a_neg_q) ? -rem_q : rem_q;
        result_d    = b_zero_q ? {a_raw_q, {W{1'b1}}} : {rem_fix_d, quo_fix_d};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            quo_q      <= '0;
            divisor_q  <= '0;
            a_raw_q    <= '0;
            signed_q   <= 1'b0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            b_zero_q   <= 1'b0;
            cnt_q      <= '0;
            ready_q    <= 1'b1;
            complete_q <= 1'b0;
            y_q        <= '0;
            rob_q      <= '0;
            hilo_q     <= '0;
        end else begin
            complete_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.go) begin
                        rob_q     <= bus.rob_ptr_in;
                        hilo_q    <= bus.hilo_prf_ptr_in;
                        signed_q  <= is_signed_d;
                        a_neg_q   <= bus.src_A[W-1];
                        b_neg_q   <= bus.src_B[W-1];
                        b_zero_q  <= (bus.src_B == '0);
                        a_raw_q   <= bus.src_A;
                        divisor_q <= b_mag_d;
                        quo_q     <= a_mag_d;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        ready_q   <= 1'b0;
                        state_q   <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    rem_q   <= trial_d[W] ? shift_d[W-1:0] : trial_d[W-1:0];
                    quo_q   <= {quo_q[W-2:0], ~trial_d[W]};
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    y_q        <= result_d;
                    complete_q <= 1'b1;
                    state_q    <= S_DONE;
                end
                S_DONE: begin
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready                = ready_q;
    assign bus.y                    = y_q;
    assign bus.complete             = complete_q;
    assign bus.rob_ptr_out          = rob_q;
    assign bus.hilo_prf_ptr_val_out = complete_q;
    assign bus.hilo_prf_ptr_out     = hilo_q;

endmodule

`default_nettype wire

// File: tb/tb_div_iter.sv
// ============================================================================
// Module      : tb_div_iter
// Description : Directed-vector bench for div_iter: latency, back-pressure,
//               signed/unsigned arithmetic, divide-by-zero and async reset.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_div_iter;
    localparam int          W      = 32;
    localparam int          LG_ROB = 6;
    localparam int          LG_HP  = 6;
    localparam int          OPC_W  = 6;
    localparam logic [5:0]  OP_DIV  = 6'h1A;
    localparam logic [5:0]  OP_DIVU = 6'h1B;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    div_iter_if #(
        .W(W), .LG_ROB_ENTRIES(LG_ROB), .LG_HILO_PRF_ENTRIES(LG_HP), .OPCODE_W(OPC_W)
    ) bus ();

    div_iter #(
        .W(W), .LG_ROB_ENTRIES(LG_ROB), .LG_HILO_PRF_ENTRIES(LG_HP),
        .OPCODE_W(OPC_W), .OP_DIVU(OP_DIVU)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_go(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [5:0] rob, input logic [5:0] hp);
        bus.opcode          = op;
        bus.src_A           = a;
        bus.src_B           = b;
        bus.rob_ptr_in      = rob;
        bus.hilo_prf_ptr_in = hp;
        bus.go              = 1'b1;
    endtask

    // Cycle 0 is the cycle in which go is driven; go is sampled at the
    // following edge and the result is expected in relative cycle 34.
    task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [5:0] rob, input logic [5:0] hp,
                          input logic [63:0] exp_y, input bit no_wait, input bit spurious);
        int rdy_bad;
        int cmp_bad;
        rdy_bad = 0;
        cmp_bad = 0;
        if (!no_wait) @(negedge clk);
        drive_go(op, a, b, rob, hp);
        for (int c = 1; c <= 35; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.go    = 1'b0;
                bus.src_A = 32'hA5A5_A5A5;
                bus.src_B = 32'h0000_0003;
            end
            if (spurious && c == 10) drive_go(OP_DIVU, 32'd7, 32'd1, 6'd9, 6'd9);
            if (spurious && c == 11) bus.go = 1'b0;
            if (c <= 34 && bus.ready !== 1'b0) rdy_bad++;
            if (c != 34 && bus.complete !== 1'b0) cmp_bad++;
            if (c == 34) begin
                check({tag, "_complete"}, 64'(bus.complete), 64'd1);
                check({tag, "_hilo_val"}, 64'(bus.hilo_prf_ptr_val_out), 64'd1);
                check({tag, "_y"}, bus.y, exp_y);
                check({tag, "_rob"}, 64'(bus.rob_ptr_out), 64'(rob));
                check({tag, "_hilo_ptr"}, 64'(bus.hilo_prf_ptr_out), 64'(hp));
            end
        end
        check({tag, "_ready_c35"}, 64'(bus.ready), 64'd1);
        check({tag, "_ready_low_cnt"}, 64'(rdy_bad), 64'd0);
        check({tag, "_stray_complete"}, 64'(cmp_bad), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        bus.opcode = '0; bus.go = 1'b0; bus.src_A = '0; bus.src_B = '0;
        bus.rob_ptr_in = '0; bus.hilo_prf_ptr_in = '0;
        repeat (2) @(negedge clk);
        check("rst_ready",    64'(bus.ready), 64'd1);
        check("rst_complete", 64'(bus.complete), 64'd0);
        check("rst_hilo_val", 64'(bus.hilo_prf_ptr_val_out), 64'd0);
        check("rst_y",        bus.y, 64'd0);
        check("rst_rob",      64'(bus.rob_ptr_out), 64'd0);
        check("rst_hilo_ptr", 64'(bus.hilo_prf_ptr_out), 64'd0);
        reset = 1'b1;

        run_op("divu_100_7",  OP_DIVU, 32'd100,        32'd7,          6'd5,  6'd3,  64'h00000002_0000000E, 0, 0);
        run_op("div_m7_2",    OP_DIV,  32'hFFFF_FFF9,  32'd2,          6'd12, 6'd4,  64'hFFFFFFFF_FFFFFFFD, 0, 0);
        run_op("div_7_m2",    OP_DIV,  32'd7,          32'hFFFF_FFFE,  6'd13, 6'd5,  64'h00000001_FFFFFFFD, 0, 0);
        run_op("divu_big_2",  OP_DIVU, 32'hFFFF_FFF9,  32'd2,          6'd14, 6'd6,  64'h00000001_7FFFFFFC, 0, 0);
        run_op("div_by0",     OP_DIV,  32'hFFFF_FFFB,  32'd0,          6'd15, 6'd7,  64'hFFFFFFFB_FFFFFFFF, 0, 0);
        run_op("divu_by0",    OP_DIVU, 32'd5,          32'd0,          6'd16, 6'd8,  64'h00000005_FFFFFFFF, 0, 0);
        run_op("div_ovf",     OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  6'd17, 6'd10, 64'h00000000_80000000, 0, 0);
        run_op("op0_signed",  6'h00,   32'hFFFF_FF9C,  32'd7,          6'd18, 6'd11, 64'hFFFFFFFE_FFFFFFF2, 0, 0);
        run_op("divu_hex",    OP_DIVU, 32'h1234_5678,  32'h0000_1000,  6'd19, 6'd12, 64'h00000678_00012345, 0, 0);

        // Ignored go at cycle 10, then a back-to-back issue in cycle 35.
        run_op("div_ign_go",  OP_DIV,  32'd1000,       32'd10,         6'd33, 6'd34, 64'h00000000_00000064, 0, 1);
        run_op("divu_b2b",    OP_DIVU, 32'hFFFF_FFFF,  32'h0000_FFFF,  6'd40, 6'd41, 64'h00000000_00010001, 1, 0);

        @(negedge clk);
        drive_go(OP_DIV, 32'd100, 32'd3, 6'd50, 6'd51);
        @(negedge clk);
        bus.go = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ready",    64'(bus.ready), 64'd1);
        check("abort_complete", 64'(bus.complete), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int c = 17; c <= 40; c++) begin
            @(negedge clk);
            if (bus.complete !== 1'b0) stray++;
        end
        check("abort_no_complete", 64'(stray), 64'd0);
        run_op("div_after_rst", OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 6'd60, 6'd61, 64'hFFFFFFFE_0000000E, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
